// File: rtl/mult_tree_pkg.sv
// mult_tree_pkg: width helpers and the saturating slice function shared by mult_tree_pipe
package mult_tree_pkg;

   // Widest full product the slice function handles (W up to 10)
   localparam int MAX_P = 64;

   function automatic int prod_w(input int w);
      return 6 * w;
   endfunction

   function automatic int cube_w(input int w);
      return 3 * w;
   endfunction

   // Returns {sat, slice}: slice is p[lsb +: ow] in the low ow bits, or all ones when any bit above it is set
   function automatic logic [MAX_P:0] slice_sat(input logic [MAX_P-1:0] p, input int lsb, input int ow);
      logic [MAX_P-1:0] sh;
      logic [MAX_P-1:0] mask;
      sh   = p >> lsb;
      mask = (ow >= MAX_P) ? '1 : (MAX_P'(1) << ow) - MAX_P'(1);
      return (|(sh & ~mask)) ? {1'b1, mask} : {1'b0, sh & mask};
   endfunction

endpackage

// File: rtl/mult_tree_pipe_xyy.sv
// mult_xyy: registered x*y*y at full 3W precision with flow-controlled valid
module mult_xyy
   import mult_tree_pkg::*;
#(
   parameter int W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [W-1:0]         x,
   input  logic [W-1:0]         y,
   output logic                 out_valid,
   output logic [cube_w(W)-1:0] xyy
);

   localparam int CW = cube_w(W);

   // Stage advances on en; data only loads when the upstream slot holds a real operand
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         xyy       <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         if (in_valid) xyy <= CW'(x) * CW'(y) * CW'(y);
      end
   end

endmodule

// File: rtl/mult_tree_pipe.sv
// mult_tree_pipe: 3-stage valid/ready pipeline computing a slice of (a*b*b)*(c*d*d); MULT_SAT_EN enables slice saturation
module mult_tree_pipe
   import mult_tree_pkg::*;
#(
   parameter int W       = 4,
   parameter int OUT_W   = 8,
   parameter int OUT_LSB = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [W-1:0]     i_a,
   input  logic [W-1:0]     i_b,
   input  logic [W-1:0]     i_c,
   input  logic [W-1:0]     i_d,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_result,
   output logic             o_sat
);

   localparam int PW = prod_w(W);
   localparam int CW = cube_w(W);

   logic          v1, v2, v3, v2a, v2b;
   logic          en1, en2, en3;
   logic [W-1:0]  a1, b1, c1, d1;
   logic [CW-1:0] abb, cdd;
   logic [PW-1:0] p;
   logic [OUT_W-1:0] res_n;

   // A stage may load when it is empty or the stage after it is moving, so bubbles collapse
   assign en3     = !v3 | i_ready;
   assign en2     = !v2 | en3;
   assign en1     = !v1 | en2;
   assign o_ready = en1;
   assign o_valid = v3;
   assign v2      = v2a & v2b;
   assign p       = PW'(abb) * PW'(cdd);

   // S1: capture operands on an accepted transfer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         {a1, b1, c1, d1} <= '0;
      end else if (en1) begin
         v1 <= i_valid;
         if (i_valid) {a1, b1, c1, d1} <= {i_a, i_b, i_c, i_d};
      end
   end

   mult_xyy #(.W(W)) u_abb (
      .clk(clk), .rst_n(rst_n), .en(en2), .in_valid(v1),
      .x(a1), .y(b1), .out_valid(v2a), .xyy(abb)
   );

   mult_xyy #(.W(W)) u_cdd (
      .clk(clk), .rst_n(rst_n), .en(en2), .in_valid(v1),
      .x(c1), .y(d1), .out_valid(v2b), .xyy(cdd)
   );

`ifdef MULT_SAT_EN
   logic [MAX_P:0] ss;
   logic           sat_n;
   assign ss    = slice_sat(MAX_P'(p), OUT_LSB, OUT_W);
   assign res_n = ss[OUT_W-1:0];
   assign sat_n = ss[MAX_P];

   // Saturation flag travels with the S3 result
   always_ff @(posedge clk) begin
      if (!rst_n) o_sat <= 1'b0;
      else if (en3 && v2) o_sat <= sat_n;
   end
`else
   assign res_n = OUT_W'(p >> OUT_LSB);
   assign o_sat = 1'b0;
`endif

   // S3: full product slice; holds while the consumer stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v3       <= 1'b0;
         o_result <= '0;
      end else if (en3) begin
         v3 <= v2;
         if (v2) o_result <= res_n;
      end
   end

endmodule

// File: tb/tb_mult_tree_pipe.sv
// tb_mult_tree_pipe: directed bench for mult_tree_pipe at OUT_LSB 16, 0 and 8 (set MULT_SAT_EN to match the RTL build)
module tb_mult_tree_pipe;

   logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
   logic [3:0] i_a = '0, i_b = '0, i_c = '0, i_d = '0;
   logic o_ready_h, o_valid_h, o_sat_h, o_ready_z, o_valid_z, o_sat_z, o_ready_m, o_valid_m, o_sat_m;
   logic [7:0] o_result_h, o_result_z, o_result_m;

   int checks = 0, errors = 0, cyc = 0, n;
   logic [23:0] exp_q[$];
   logic [7:0]  got_h[$], got_z[$], got_m[$];
   logic        got_s[$];
   int          got_cyc[$];

   localparam logic [15:0] BB [8] = '{16'h2312, 16'h1111, 16'h3223, 16'hF0FF, 16'h7A5B, 16'h4444, 16'h9182, 16'hFFFF};
   localparam logic [15:0] BP [5] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF1, 16'h2222};

   always #5 clk = ~clk;

   mult_tree_pipe #(.W(4), .OUT_W(8), .OUT_LSB(16)) dut_h (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_h), .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
      .o_valid(o_valid_h), .i_ready(i_ready), .o_result(o_result_h), .o_sat(o_sat_h));
   mult_tree_pipe #(.W(4), .OUT_W(8), .OUT_LSB(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_z), .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
      .o_valid(o_valid_z), .i_ready(i_ready), .o_result(o_result_z), .o_sat(o_sat_z));
   mult_tree_pipe #(.W(4), .OUT_W(8), .OUT_LSB(8)) dut_m (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_m), .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
      .o_valid(o_valid_m), .i_ready(i_ready), .o_result(o_result_m), .o_sat(o_sat_m));

   function automatic logic [23:0] pfun(input logic [15:0] op);
      logic [23:0] x, y;
      x = 24'(op[15:12]) * 24'(op[11:8]) * 24'(op[11:8]);
      y = 24'(op[7:4]) * 24'(op[3:0]) * 24'(op[3:0]);
      return x * y;
   endfunction

   function automatic logic [7:0] sl8(input logic [23:0] p);
`ifdef MULT_SAT_EN
      return (p[23:16] != 8'h00) ? 8'hFF : p[15:8];
`else
      return p[15:8];
`endif
   endfunction

   function automatic logic sat8(input logic [23:0] p);
`ifdef MULT_SAT_EN
      return |p[23:16];
`else
      return 1'b0;
`endif
   endfunction

   // Drive one cycle's inputs at the falling edge, then log what the coming rising edge will transfer
   task automatic step(input logic v, input logic [15:0] op, input logic r);
      @(negedge clk);
      i_valid = v;
      {i_a, i_b, i_c, i_d} = op;
      i_ready = r;
      #1;
      if (i_valid && o_ready_h) exp_q.push_back(pfun(op));
      if (o_valid_h && i_ready) begin
         got_h.push_back(o_result_h);
         got_z.push_back(o_result_z);
         got_m.push_back(o_result_m);
         got_s.push_back(o_sat_m);
         got_cyc.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic clear_q();
      exp_q.delete(); got_h.delete(); got_z.delete(); got_m.delete(); got_s.delete(); got_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      checks++; if ({o_valid_h, o_valid_z, o_valid_m} !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b want 000", {o_valid_h, o_valid_z, o_valid_m}); end
      checks++; if ({o_result_h, o_result_z, o_result_m} !== 24'h0) begin errors++; $display("FAIL reset_result: got %h want 000000", {o_result_h, o_result_z, o_result_m}); end
      checks++; if ({o_sat_h, o_sat_z, o_sat_m} !== 3'b000) begin errors++; $display("FAIL reset_sat: got %b want 000", {o_sat_h, o_sat_z, o_sat_m}); end
      checks++; if (o_ready_h !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready_h); end
      rst_n = 1'b1;
      clear_q();
   endtask

   task automatic test_latency();
      clear_q();
      step(1'b1, 16'hFFFF, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, 16'h0, 1'b1);
         checks++; if (o_valid_h !== (k == 3)) begin errors++; $display("FAIL latency_valid cycle %0d: got %b want %b", k, o_valid_h, k == 3); end
      end
      checks++; if (o_result_h !== 8'hAD) begin errors++; $display("FAIL lat_result_hi: got %h want ad", o_result_h); end
      checks++; if (o_sat_h !== 1'b0) begin errors++; $display("FAIL lat_sat_hi: got %b want 0", o_sat_h); end
      checks++; if (o_result_z !== 8'hA1) begin errors++; $display("FAIL lat_result_lo: got %h want a1", o_result_z); end
`ifdef MULT_SAT_EN
      checks++; if ({o_sat_m, o_result_m} !== 9'h1FF) begin errors++; $display("FAIL lat_mid_sat: got %b/%h want 1/ff", o_sat_m, o_result_m); end
`else
      checks++; if ({o_sat_m, o_result_m} !== 9'h0CE) begin errors++; $display("FAIL lat_mid_trunc: got %b/%h want 0/ce", o_sat_m, o_result_m); end
`endif
      step(1'b0, 16'h0, 1'b1);
      checks++; if (o_valid_h !== 1'b0) begin errors++; $display("FAIL lat_single: got o_valid %b want 0", o_valid_h); end
   endtask

   task automatic test_back_to_back();
      clear_q();
      for (int i = 0; i < 8; i++) step(1'b1, BB[i], 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);
      checks++; if (got_h.size() !== 8 || exp_q.size() !== 8) begin errors++; $display("FAIL b2b_count: got %0d results %0d accepts want 8", got_h.size(), exp_q.size()); end
      checks++; if (got_z.size() == 0 || got_z[0] !== 8'h48) begin errors++; $display("FAIL b2b_first: got %h want 48", got_z.size() ? got_z[0] : 8'hxx); end
      for (int i = 0; i < got_h.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_h[i] !== exp_q[i][23:16] || got_z[i] !== exp_q[i][7:0] || got_m[i] !== sl8(exp_q[i]) || got_s[i] !== sat8(exp_q[i]))
            begin errors++; $display("FAIL b2b_data[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b", i, got_h[i], got_z[i], got_m[i], got_s[i], exp_q[i][23:16], exp_q[i][7:0], sl8(exp_q[i]), sat8(exp_q[i])); end
         checks++;
         if (got_cyc[i] !== got_cyc[0] + i) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, got_cyc[i], got_cyc[0] + i); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] first;
      clear_q();
      for (int t = 0; t < 6; t++) begin
         n = exp_q.size();
         step(n < 5, BP[n % 5], 1'b0);
      end
      checks++; if (exp_q.size() !== 3) begin errors++; $display("FAIL bp_accepts: got %0d want 3", exp_q.size()); end
      checks++; if (o_ready_h !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", o_ready_h); end
      first = pfun(BP[0]) >> 16;
      for (int t = 0; t < 3; t++) begin
         checks++;
         if (o_valid_h !== 1'b1 || o_result_h !== first) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", t, o_valid_h, o_result_h, first); end
         step(1'b1, BP[3], 1'b0);
      end
      for (int t = 0; t < 20 && got_h.size() < 5; t++) begin
         n = exp_q.size();
         step(n < 5, BP[n % 5], 1'b1);
      end
      for (int t = 0; t < 3; t++) step(1'b0, 16'h0, 1'b1);
      checks++; if (got_h.size() !== 5 || exp_q.size() !== 5) begin errors++; $display("FAIL bp_drain_count: got %0d results %0d accepts want 5", got_h.size(), exp_q.size()); end
      for (int i = 0; i < got_h.size() && i < 5; i++) begin
         checks++;
         if (got_h[i] !== pfun(BP[i]) >> 16 || got_z[i] !== 8'(pfun(BP[i])) || got_m[i] !== sl8(pfun(BP[i])))
            begin errors++; $display("FAIL bp_order[%0d]: got %h/%h/%h want %h/%h/%h", i, got_h[i], got_z[i], got_m[i], pfun(BP[i]) >> 16, 8'(pfun(BP[i])), sl8(pfun(BP[i]))); end
      end
   endtask

   task automatic test_bubble();
      logic [7:0] x_hi;
      clear_q();
      x_hi = pfun(16'h3223) >> 16;
      step(1'b1, 16'h3223, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b1, 16'hFFFF, 1'b1);
      for (int t = 3; t <= 6; t++) begin
         step(1'b0, 16'h0, 1'b0);
         checks++;
         if (o_ready_h !== 1'b1 || o_valid_h !== 1'b1 || o_result_h !== x_hi) begin errors++; $display("FAIL bubble_stall[%0d]: got rdy %b vld %b res %h want 1 1 %h", t, o_ready_h, o_valid_h, o_result_h, x_hi); end
      end
      for (int t = 0; t < 5; t++) step(1'b0, 16'h0, 1'b1);
      checks++; if (got_h.size() !== 2) begin errors++; $display("FAIL bubble_count: got %0d want 2", got_h.size()); end
      if (got_h.size() == 2) begin
         checks++; if (got_z[0] !== 8'hD8 || got_h[1] !== 8'hAD) begin errors++; $display("FAIL bubble_order: got %h,%h want d8,ad", got_z[0], got_h[1]); end
         checks++; if (got_cyc[1] !== got_cyc[0] + 1) begin errors++; $display("FAIL bubble_gap: got %0d cycles apart want 1", got_cyc[1] - got_cyc[0]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      for (int i = 0; i < 3; i++) step(1'b1, BP[i], 1'b0);
      rst_n = 1'b0;
      step(1'b0, 16'h0, 1'b0);
      checks++; if (o_valid_h !== 1'b0 || o_result_h !== 8'h00 || o_result_z !== 8'h00) begin errors++; $display("FAIL rstmid_out: got %b/%h/%h want 0/00/00", o_valid_h, o_result_h, o_result_z); end
      checks++; if (o_ready_h !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", o_ready_h); end
      rst_n = 1'b1;
      for (int t = 0; t < 2; t++) begin
         step(1'b0, 16'h0, 1'b1);
         checks++; if (o_valid_h !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: got %b want 0", t, o_valid_h); end
      end
      step(1'b1, 16'h795B, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, 16'h0, 1'b1);
         checks++; if (o_valid_h !== (k == 3)) begin errors++; $display("FAIL rstmid_latency[%0d]: got %b want %b", k, o_valid_h, k == 3); end
      end
      checks++; if (o_result_h !== 8'h05 || o_result_z !== 8'hFB) begin errors++; $display("FAIL rstmid_result: got %h/%h want 05/fb", o_result_h, o_result_z); end
      step(1'b0, 16'h0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_bubble();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule

// File: doc/mult_tree_pipe.md
Name: mult_tree_pipe

Overview:
- Parametrised, flow-controlled successor of the fixed 4-bit multiply tree.
- Computes P = (a*b*b) * (c*d*d) at full internal precision through a 3-stage pipeline with valid/ready handshakes and per-stage bubble collapsing.
- Presents a programmable OUT_W-bit slice of P.
- Sits between a streaming operand source and any valid/ready consumer in the datapath.

Parameters:
- W, 4: width of each unsigned operand.
- OUT_W, 8: width of o_result.
- OUT_LSB, 16: bit index of P mapped to o_result[0]. Requires OUT_LSB+OUT_W <= 6*W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  operand set i_a..i_d valid
- o_ready  out  1  block accepts operands this cycle
- i_a, i_b, i_c, i_d  in  W each  unsigned operands
- o_valid  out  1  o_result valid
- i_ready  in  1  downstream accepts o_result
- o_result  out  OUT_W  selected slice of P
- o_sat  out  1  slice saturated; constant 0 when MULT_SAT_EN is undefined

Behaviour:
- One clock; reset is synchronous and active-low, sampled on rising clk.
- While rst_n=0: all stage valids, o_valid, o_result, o_sat and data registers go to 0 on the next edge.
- Reset mid-operation discards all in-flight data. No output appears for pre-reset inputs.
- Stage 1 (S1): registers a, b, c, d; valid v1.
- Stage 2 (S2): abb = a*b*b and cdd = c*d*d, each 3W bits, exact; valid v2.
- Stage 3 (S3): P = abb*cdd, 6W bits, exact; o_valid = v3.
- Output mapping: o_result = P[OUT_LSB +: OUT_W], registered with P in S3.
- Advance rule:
  - en3 = !v3 | i_ready
  - en2 = !v2 | en3
  - en1 = !v1 | en2
  - o_ready = en1 (combinational from i_ready and the valid regs)
- Transfer occurs when i_valid & o_ready. Stage k loads when en_k.
  - Its valid becomes the upstream valid. For S1 that is i_valid & o_ready.
  - Data registers load only when en_k and the upstream valid is 1.
- Latency: 3 cycles from accepted input to o_valid, when unstalled.
- Throughput: 1 result per cycle while i_ready=1.
- Stall:
  - While o_valid=1 and i_ready=0, o_result and o_sat hold stable.
  - Upstream stages still fill bubbles.
  - At most 3 results are in flight. With all stages full and i_ready=0, o_ready=0.
- Simultaneous accept into S1 and drain from S3 in the same cycle is legal. No data is lost or duplicated.
- Results leave in input order.
- Operands are unsigned. No rounding; the slice truncates low bits below OUT_LSB.

Optional Feature:
- Macro: MULT_SAT_EN.
- Defined:
  - If any bit of P above OUT_LSB+OUT_W-1 is 1, o_result = all ones and o_sat = 1. Otherwise o_sat = 0.
  - Evaluated in S3 and registered with o_result.
  - With OUT_LSB+OUT_W = 6*W there are no upper bits, so o_sat is always 0.
- Undefined: plain truncation of the upper bits; o_sat tied to 0.

Decomposition:
- Package mult_tree_pkg holds:
  - localparam width helpers: PROD_W(W) = 6*W and CUBE_W(W) = 3*W
  - a function slice_sat(P, OUT_LSB, OUT_W) returning {sat, slice}
- Natural sub-module: mult_xyy, computing x*y*y registered with valid and enable.
  - Instanced twice in S2, for abb and cdd.
- S1 and S3 stay in the top.

Test Plan:
- Default params; a=b=c=d=15, i_ready=1 -> P=0xADCEA1; o_valid exactly 3 cycles after accept with o_result=0xAD, o_sat=0.
- W=4, OUT_W=8, OUT_LSB=0; a=2, b=3, c=1, d=2 -> abb=18, cdd=4, o_result=0x48. Back-to-back stream of 8 vectors yields 8 results on 8 consecutive cycles, in order.
- W=4, OUT_W=8, OUT_LSB=8; a=b=c=d=15:
  - MULT_SAT_EN undefined -> o_result=0xCE, o_sat=0.
  - MULT_SAT_EN defined -> o_result=0xFF, o_sat=1.
- Backpressure: i_ready=0 while streaming 5 vectors -> o_ready drops after 3 accepts. o_result holds the first result unchanged. Releasing i_ready drains all 5 in order with no loss or duplicate.
- Bubble collapse: input valid on cycles 0 and 2, i_ready=0 from cycle 3 to 6 -> the gap closes, S2 and S3 both full, o_ready=1 while S1 is empty.
- Reset mid-flight: 3 vectors in pipe, rst_n=0 for 1 cycle -> o_valid=0, o_result=0 next edge. No stale result appears afterwards; the first post-reset input appears after 3 cycles.
